sys_time_gen: RTL and testbench

- Produces the free-running 64-bit SYS_TIME that sync_time_cnt_gen consumes.
- Time is set by a host-supplied value, and that value takes effect on the next EtherCAT SYNC0 edge.
- After the load, every SYNC0 edge is checked against the expected sync period.
- The block reports lock status and the signed interval error for monitoring.

---
 rtl/sys_time_pkg.sv | 6 +
 rtl/sync0_edge_det.sv | 24 ++
 rtl/sys_time_gen.sv | 94 +++++++++
 tb/tb_sys_time_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sys_time_pkg.sv
// Shared types and widths for the SYNC0-disciplined system time generator.
package sys_time_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} sys_time_state_t;
  localparam int SYS_TIME_W = 64;
  localparam int ERR_W_DEF  = 32;
endpackage

// File: rtl/sync0_edge_det.sv
// SYNC0 synchronizer chain followed by a registered one-cycle rising-edge pulse.
module sync0_edge_det #(
  parameter int SYNC_STAGES = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic SYNC0,
  output logic EDGE
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      last_q <= 1'b0;
      EDGE   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SYNC0};
      last_q <= sync_q[SYNC_STAGES-1];
      EDGE   <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end
endmodule

// File: rtl/sys_time_gen.sv
// Free-running 64-bit system time, loaded on SYNC0 and monitored against the sync period.
//   state | meaning
//   IDLE  | free running, no time loaded, edges ignored
//   ARMED | SET_TIME captured, waiting for the SYNC0 edge that loads it
//   RUN   | time loaded, each edge measured against SYNC_PERIOD
module sys_time_gen
  import sys_time_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int ERR_W       = ERR_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SYNC0,
  input  logic [SYS_TIME_W-1:0] SET_TIME,
  input  logic                  SET_VALID,
  output logic                  SET_READY,
  input  logic [ERR_W-1:0]      SYNC_PERIOD,
  output logic [SYS_TIME_W-1:0] SYS_TIME,
  output logic                  LOCKED,
  output logic [ERR_W-1:0]      SYNC_ERR,
  output logic                  ERR_VALID
);
  sys_time_state_t       state, state_nxt;
  logic                  edge_p;
  logic                  xfer, load, run_edge, timeout, period_on;
  logic [SYS_TIME_W-1:0] pending;
  logic [ERR_W-1:0]      cnt;
  logic [ERR_W:0]        diff;
  logic [ERR_W-1:0]      err_sat;

  sync0_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .CLK  (CLK),
    .RST  (RST),
    .SYNC0(SYNC0),
    .EDGE (edge_p)
  );

  assign SET_READY = (state != ARMED);
  assign xfer      = SET_VALID & SET_READY;
  assign load      = (state == ARMED) & edge_p;
  assign run_edge  = (state == RUN) & edge_p;
  assign period_on = (SYNC_PERIOD != '0);
  assign timeout   = ({1'b0, cnt} > {SYNC_PERIOD, 1'b0});

  // Measured interval is cnt+1; the true difference always fits in ERR_W+1 signed bits.
  always_comb begin
    diff = {1'b0, cnt} + {{ERR_W{1'b0}}, 1'b1} - {1'b0, SYNC_PERIOD};
    if (diff[ERR_W] != diff[ERR_W-1])
      err_sat = {diff[ERR_W], {(ERR_W-1){~diff[ERR_W]}}};
    else
      err_sat = diff[ERR_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer)   state_nxt = ARMED;
      ARMED:   if (edge_p) state_nxt = RUN;
      RUN:     if (xfer)   state_nxt = ARMED;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SYS_TIME  <= '0;
      pending   <= '0;
      cnt       <= '0;
      LOCKED    <= 1'b0;
      SYNC_ERR  <= '0;
      ERR_VALID <= 1'b0;
    end else begin
      SYS_TIME  <= load ? pending : SYS_TIME + 1'b1;
      ERR_VALID <= 1'b0;
      if (xfer) pending <= SET_TIME;
      if (load || run_edge)  cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + 1'b1;
      if (run_edge && period_on) begin
        SYNC_ERR  <= err_sat;
        ERR_VALID <= 1'b1;
      end
      if (load || run_edge)                          LOCKED <= 1'b1;
      else if (state == RUN && period_on && timeout) LOCKED <= 1'b0;
      // A new transfer always drops lock, even when it coincides with a RUN edge.
      if (xfer) LOCKED <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sys_time_gen.sv
// Directed bench for sys_time_gen: load, interval error, timeout, wrap, coincidence, reset.
module tb_sys_time_gen;
  logic        CLK = 1'b0;
  logic        RST;
  logic        SYNC0;
  logic [63:0] SET_TIME;
  logic        SET_VALID;
  logic        SET_READY;
  logic [31:0] SYNC_PERIOD;
  logic [63:0] SYS_TIME;
  logic        LOCKED;
  logic [31:0] SYNC_ERR;
  logic        ERR_VALID;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          ev_cnt = 0;
  int          ev0;
  logic [31:0] last_err = '0;

  sys_time_gen #(.SYNC_STAGES(3), .ERR_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SYNC0      (SYNC0),
    .SET_TIME   (SET_TIME),
    .SET_VALID  (SET_VALID),
    .SET_READY  (SET_READY),
    .SYNC_PERIOD(SYNC_PERIOD),
    .SYS_TIME   (SYS_TIME),
    .LOCKED     (LOCKED),
    .SYNC_ERR   (SYNC_ERR),
    .ERR_VALID  (ERR_VALID)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ERR_VALID === 1'b1) begin
      ev_cnt   = ev_cnt + 1;
      last_err = SYNC_ERR;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_xfer(input logic [63:0] t);
    SET_TIME  = t;
    SET_VALID = 1'b1;
    wait_cyc(1);
    SET_VALID = 1'b0;
  endtask

  // Rising SYNC0 now, high 3 cycles, returns gap cycles after the rise.
  task automatic pulse_wait(input int gap);
    SYNC0 = 1'b1;
    wait_cyc(3);
    SYNC0 = 1'b0;
    wait_cyc(gap - 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; SYNC0 = 1'b0; SET_TIME = '0; SET_VALID = 1'b0; SYNC_PERIOD = '0;
    wait_cyc(2);
    chk("rst_time",   SYS_TIME, 64'd0);
    chk("rst_ready",  64'(SET_READY), 64'd1);
    chk("rst_locked", 64'(LOCKED), 64'd0);
    chk("rst_err",    64'(SYNC_ERR), 64'd0);
    chk("rst_ev",     64'(ERR_VALID), 64'd0);
    RST = 1'b0;
    wait_cyc(1);
    chk("free_t0", SYS_TIME, 64'd1);
    wait_cyc(100);
    chk("free_t100", SYS_TIME, 64'd101);
    chk("free_locked", 64'(LOCKED), 64'd0);
    chk("free_ready", 64'(SET_READY), 64'd1);

    // Load 0x1000 on the first edge
    SYNC_PERIOD = 32'd1000;
    do_xfer(64'h1000);
    chk("armed_ready", 64'(SET_READY), 64'd0);
    SYNC0 = 1'b1;
    wait_cyc(3);
    SYNC0 = 1'b0;
    wait_cyc(1);
    chk("armed_ready_pre_edge", 64'(SET_READY), 64'd0);
    chk("armed_locked", 64'(LOCKED), 64'd0);
    wait_cyc(1);
    chk("load_time", SYS_TIME, 64'h1000);
    chk("load_locked", 64'(LOCKED), 64'd1);
    chk("load_ready", 64'(SET_READY), 64'd1);
    wait_cyc(1);
    chk("load_time_p1", SYS_TIME, 64'h1001);
    chk("load_no_ev", 64'(ev_cnt), 64'd0);
    wait_cyc(994);

    // Intervals of 1000, 1003, 997
    ev0 = ev_cnt;
    pulse_wait(1003);
    chk("err0_cnt", 64'(ev_cnt - ev0), 64'd1);
    chk("err0_val", 64'(last_err), 64'd0);
    pulse_wait(997);
    chk("errp3_cnt", 64'(ev_cnt - ev0), 64'd2);
    chk("errp3_val", 64'(last_err), 64'd3);
    pulse_wait(20);
    chk("errm3_cnt", 64'(ev_cnt - ev0), 64'd3);
    chk("errm3_val", 64'(last_err), 64'h0000_0000_FFFF_FFFD);
    chk("run_locked", 64'(LOCKED), 64'd1);

    // Timeout with period 100: edge was processed 15 cycles ago
    SYNC_PERIOD = 32'd100;
    wait_cyc(186);
    chk("to_still_locked", 64'(LOCKED), 64'd1);
    wait_cyc(1);
    chk("to_unlocked", 64'(LOCKED), 64'd0);
    pulse_wait(5);
    chk("to_relock", 64'(LOCKED), 64'd1);

    // Wrap through 2^64
    do_xfer(64'hFFFF_FFFF_FFFF_FFFE);
    chk("rearm_locked", 64'(LOCKED), 64'd0);
    chk("rearm_ready", 64'(SET_READY), 64'd0);
    pulse_wait(5);
    chk("wrap_fe", SYS_TIME, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_cyc(1);
    chk("wrap_ff", SYS_TIME, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_cyc(1);
    chk("wrap_0", SYS_TIME, 64'd0);
    wait_cyc(1);
    chk("wrap_1", SYS_TIME, 64'd1);

    // Transfer coinciding with a RUN edge (interval 8 against period 100)
    SYNC0 = 1'b1;
    wait_cyc(3);
    SYNC0 = 1'b0;
    wait_cyc(1);
    SET_TIME  = 64'h5000;
    SET_VALID = 1'b1;
    wait_cyc(1);
    SET_VALID = 1'b0;
    chk("coin_no_load", SYS_TIME, 64'd6);
    chk("coin_ev", 64'(ERR_VALID), 64'd1);
    chk("coin_err", 64'(SYNC_ERR), 64'h0000_0000_FFFF_FFA4);
    chk("coin_locked", 64'(LOCKED), 64'd0);
    chk("coin_ready", 64'(SET_READY), 64'd0);
    wait_cyc(5);
    pulse_wait(5);
    chk("coin_load", SYS_TIME, 64'h5000);
    chk("coin_load_locked", 64'(LOCKED), 64'd1);
    wait_cyc(1);
    chk("coin_load_p1", SYS_TIME, 64'h5001);

    // Reset while ARMED discards the pending load
    do_xfer(64'h9000);
    chk("rst_armed_ready", 64'(SET_READY), 64'd0);
    RST = 1'b1;
    #1;
    chk("rst_async_time", SYS_TIME, 64'd0);
    chk("rst_async_ready", 64'(SET_READY), 64'd1);
    wait_cyc(1);
    RST = 1'b0;
    ev0 = ev_cnt;
    pulse_wait(5);
    chk("rst_no_load", SYS_TIME, 64'd5);
    chk("rst_no_lock", 64'(LOCKED), 64'd0);
    chk("rst_no_ev", 64'(ev_cnt - ev0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
